// File: rtl/flow_ctrl_multi_pkg.sv
// Shared state codes and channel-control modes for the flow-control blocks.
// The `defines stay visible to any file compiled after this one.
`ifndef FLOW_CTRL_DEFS
`define FLOW_CTRL_DEFS
`define FC_INIT   3'b000
`define FC_IDLE   3'b001
`define FC_ACTIVE 3'b010
`define FC_ERROR  3'b011
`endif

package flow_ctrl_multi_pkg;

    typedef enum logic [2:0] {
        ST_INIT   = `FC_INIT,
        ST_IDLE   = `FC_IDLE,
        ST_ACTIVE = `FC_ACTIVE,
        ST_ERROR  = `FC_ERROR
    } state_e;

    // What every channel does on the coming edge, derived from the state being entered
    typedef enum logic [1:0] {
        CH_CLR = 2'd0,
        CH_RUN = 2'd1,
        CH_ERR = 2'd2
    } ch_mode_e;

endpackage

// File: rtl/flow_ctrl_canal.sv
// One monitored FIFO channel: full/busy detect, pause hysteresis flop,
// continue pulse and sticky full-error bit.
module flow_ctrl_canal
    import flow_ctrl_multi_pkg::*;
#(
    parameter int CW    = 4,
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  ch_mode_e      mode,
    input  logic [CW-1:0] occ,
    input  logic [CW-1:0] af,
    input  logic [CW-1:0] ae,
    output logic          full,
    output logic          busy,
    output logic          pausa,
    output logic          continuar,
    output logic          error_full
);

    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);

    logic hyst;

    assign full = (occ >= FULL_LVL);
    assign busy = (occ != '0);

    // ae < af is guaranteed by the threshold check, so set and clear never overlap
    always_comb begin
        hyst = pausa;
        if (occ >= af)
            hyst = 1'b1;
        else if (occ <= ae)
            hyst = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pausa      <= 1'b0;
            continuar  <= 1'b0;
            error_full <= 1'b0;
        end else begin
            case (mode)
                CH_RUN: begin
                    pausa      <= hyst;
                    continuar  <= pausa & ~hyst;
                    error_full <= 1'b0;
                end
                CH_ERR: begin
                    pausa      <= 1'b1;
                    continuar  <= 1'b0;
                    error_full <= error_full | full;
                end
                default: begin
                    pausa      <= 1'b0;
                    continuar  <= 1'b0;
                    error_full <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/flow_ctrl_multi.sv
// Flow-control FSM over NCH FIFO channels: threshold latch, global state,
// and per-channel pause/continue/error control through flow_ctrl_canal.
module flow_ctrl_multi
    import flow_ctrl_multi_pkg::*;
#(
    parameter int  NCH   = 4,
    parameter int  DEPTH = 8,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iniciar,
    input  logic [CW-1:0]     umbral_af,
    input  logic [CW-1:0]     umbral_ae,
    input  logic [NCH*CW-1:0] ocupacion,
    input  logic              clr_error,
    output logic [NCH-1:0]    pausa,
    output logic [NCH-1:0]    continuar,
    output logic [NCH-1:0]    error_full,
    output logic              idle,
    output logic              cfg_err,
    output logic [2:0]        estado
);

    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);

    state_e        state_q, state_d;
    ch_mode_e      ch_mode;
    logic [CW-1:0] af_q, ae_q;
    logic [NCH-1:0] full_v, busy_v;
    logic          any_full, any_busy, cfg_ok;

    assign any_full = |full_v;
    assign any_busy = |busy_v;
    assign cfg_ok   = (umbral_ae < umbral_af) && (umbral_af <= FULL_LVL);
    assign estado   = state_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_INIT;
        else        state_q <= state_d;
    end

    // A full channel outranks every other transition outside INIT
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:   if (iniciar && cfg_ok) state_d = ST_IDLE;
            ST_IDLE:   if (any_full) state_d = ST_ERROR;
                       else if (any_busy) state_d = ST_ACTIVE;
            ST_ACTIVE: if (any_full) state_d = ST_ERROR;
                       else if (!any_busy) state_d = ST_IDLE;
            ST_ERROR:  if (clr_error && !any_full) state_d = ST_IDLE;
            default:   state_d = ST_INIT;
        endcase
    end

    always_comb begin
        ch_mode = CH_CLR;
        case (state_d)
            ST_ACTIVE: ch_mode = CH_RUN;
            ST_ERROR:  ch_mode = CH_ERR;
            default:   ch_mode = CH_CLR;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            af_q    <= '0;
            ae_q    <= '0;
            cfg_err <= 1'b0;
            idle    <= 1'b0;
        end else begin
            if (state_q == ST_INIT && iniciar) begin
                af_q    <= umbral_af;
                ae_q    <= umbral_ae;
                cfg_err <= !cfg_ok;
            end
            idle <= (state_d == ST_IDLE);
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        flow_ctrl_canal #(.CW(CW), .DEPTH(DEPTH)) u_canal (
            .clk        (clk),
            .reset      (reset),
            .mode       (ch_mode),
            .occ        (ocupacion[i*CW +: CW]),
            .af         (af_q),
            .ae         (ae_q),
            .full       (full_v[i]),
            .busy       (busy_v[i]),
            .pausa      (pausa[i]),
            .continuar  (continuar[i]),
            .error_full (error_full[i])
        );
    end

endmodule
